// File: rtl/led_display_pkg.sv
// Shared types for the LED word display: runtime modes, sequencer states and PWM width.
package led_display_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_STEP   = 2'd1,
        MODE_FREEZE = 2'd2
    } disp_mode_e;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } disp_state_e;

    localparam int PWM_W = 8;

    // The reserved encoding 3 falls back to auto-cycling.
    function automatic disp_mode_e decode_mode(input logic [1:0] mode_raw);
        case (mode_raw)
            2'd1:    return MODE_STEP;
            2'd2:    return MODE_FREEZE;
            default: return MODE_AUTO;
        endcase
    endfunction

endpackage

// File: rtl/led_word_display_pwm.sv
// Free-running PWM: output is high while the phase counter is below the duty value.
module pwm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pwm_out = (cnt_q < duty);

endmodule

// File: rtl/led_word_display.sv
// Shows a snapshotted word one digit at a time on an LED bank, with a position
// LED (flash at digit start, then PWM) and auto / step / freeze sequencing.
module led_word_display
    import led_display_pkg::*;
#(
    parameter  int VALUE_WIDTH  = 32,
    parameter  int DIGIT_WIDTH  = 4,
    parameter  int DIGIT_CYCLES = 6_000_000,
    parameter  int FLASH_CYCLES = 1_200_000,
    parameter  int GAP_CYCLES   = 12_000_000,
    parameter  int MSB_FIRST    = 1,
    localparam int N            = VALUE_WIDTH / DIGIT_WIDTH,
    localparam int IDX_W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic [1:0]             mode,
    input  logic                   step,
    output logic [DIGIT_WIDTH-1:0] leds,
    output logic                   led_pos,
    output logic [IDX_W-1:0]       digit_idx,
    output logic                   frame_start
);

    generate
        if ((VALUE_WIDTH % DIGIT_WIDTH) != 0 || VALUE_WIDTH < DIGIT_WIDTH) begin : g_bad_width
            $error("led_word_display: VALUE_WIDTH must be a multiple of DIGIT_WIDTH");
        end
    endgenerate

    localparam int CNT_MAX = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] FLASH_LIM = CNT_W'(FLASH_CYCLES);
    localparam logic [IDX_W-1:0] POS_LAST  = IDX_W'(N - 1);

    disp_state_e            state_q, state_d;
    logic [IDX_W-1:0]       pos_q, pos_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [VALUE_WIDTH-1:0] snap_q, snap_d;
    logic                   frame_start_q, frame_start_d;

    disp_mode_e             mode_s;
    logic                   terminal_s;
    logic [IDX_W-1:0]       digit_sel_s;
    logic [DIGIT_WIDTH-1:0] digit_s;
    logic [PWM_W-1:0]       duty_s;
    logic                   pwm_out_s;

    assign mode_s      = decode_mode(mode);
    assign digit_sel_s = (MSB_FIRST != 0) ? (POS_LAST - pos_q) : pos_q;
    assign digit_s     = snap_q[digit_sel_s * DIGIT_WIDTH +: DIGIT_WIDTH];
    assign duty_s      = {PWM_W{1'b1}} >> pos_q;

    pwm #(
        .WIDTH (PWM_W)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty_s),
        .pwm_out (pwm_out_s)
    );

    // Sequencer: the terminal event ends a digit (or the gap); STEP saturates the counter.
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        cnt_d         = cnt_q;
        snap_d        = snap_q;
        frame_start_d = 1'b0;
        terminal_s    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                snap_d        = value;
                pos_d         = '0;
                cnt_d         = '0;
                state_d       = ST_SHOW;
                frame_start_d = 1'b1;
            end
            ST_SHOW: begin
                case (mode_s)
                    MODE_STEP:   terminal_s = step;
                    MODE_FREEZE: terminal_s = 1'b0;
                    default:     terminal_s = (cnt_q >= DIG_LAST);
                endcase
                if (terminal_s) begin
                    cnt_d = '0;
                    if (pos_q == POS_LAST) begin
                        state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_LOAD;
                    end else begin
                        pos_d = pos_q + IDX_W'(1);
                    end
                end else if (mode_s == MODE_AUTO || (mode_s == MODE_STEP && cnt_q < DIG_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_GAP: begin
                case (mode_s)
                    MODE_STEP:   terminal_s = step;
                    MODE_FREEZE: terminal_s = 1'b0;
                    default:     terminal_s = (cnt_q >= GAP_LAST);
                endcase
                if (terminal_s) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else if (mode_s == MODE_AUTO || (mode_s == MODE_STEP && cnt_q < GAP_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            pos_q         <= '0;
            cnt_q         <= '0;
            snap_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            cnt_q         <= cnt_d;
            snap_q        <= snap_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Outputs are blanked combinationally by rst so a mid-frame reset darkens the LEDs at once.
    always_comb begin
        leds        = '0;
        led_pos     = 1'b0;
        digit_idx   = '0;
        frame_start = frame_start_q & ~rst;
        if (!rst && state_q == ST_SHOW) begin
            leds      = digit_s;
            digit_idx = pos_q;
            if (cnt_q < FLASH_LIM) begin
                led_pos = 1'b1;
            end else if (pos_q == POS_LAST) begin
                led_pos = 1'b0;
            end else begin
                led_pos = pwm_out_s;
            end
        end else begin
            leds      = '0;
            led_pos   = 1'b0;
            digit_idx = '0;
        end
    end

endmodule

// File: tb/tb_led_word_display.sv
// Randomised and directed bench for led_word_display; a frame-timeline model predicts every output.
module tb_led_word_display;

    localparam int N      = 4;
    localparam int D      = 8;
    localparam int F      = 2;
    localparam int G      = 4;
    localparam int PERIOD = 1 + N * D + G;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'hA5C3;
    logic [1:0]  mode = 2'd0;
    logic        step = 1'b0;

    logic [3:0] leds_m, leds_l;
    logic       led_pos_m, led_pos_l;
    logic [1:0] idx_m, idx_l;
    logic       fs_m, fs_l;
    logic [15:0] obs;

    int checks = 0;
    int failures = 0;

    // Model: t is the position on the frame timeline (0 = load, 1..N*D = digits, rest = gap).
    int          t = 0;
    int          prev_t = -1;
    int          ph = 0;
    logic [15:0] snap = 16'h0;

    always #5 clk = ~clk;

    led_word_display #(
        .VALUE_WIDTH(16), .DIGIT_WIDTH(4), .DIGIT_CYCLES(D), .FLASH_CYCLES(F),
        .GAP_CYCLES(G), .MSB_FIRST(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .mode(mode), .step(step),
        .leds(leds_m), .led_pos(led_pos_m), .digit_idx(idx_m), .frame_start(fs_m)
    );

    led_word_display #(
        .VALUE_WIDTH(16), .DIGIT_WIDTH(4), .DIGIT_CYCLES(D), .FLASH_CYCLES(F),
        .GAP_CYCLES(G), .MSB_FIRST(0)
    ) dut_lsb (
        .clk(clk), .rst(rst), .value(value), .mode(mode), .step(step),
        .leds(leds_l), .led_pos(led_pos_l), .digit_idx(idx_l), .frame_start(fs_l)
    );

    assign obs = {leds_m, led_pos_m, idx_m, fs_m, leds_l, led_pos_l, idx_l, fs_l};

    task automatic tick();
        int p, c, g;
        @(posedge clk);
        prev_t = t;
        if (rst) begin
            t = 0; ph = 0; snap = 16'h0;
        end else begin
            ph = (ph + 1) % 256;
            if (t == 0) begin
                snap = value;
                t = 1;
            end else if (t <= N * D) begin
                p = (t - 1) / D;
                c = (t - 1) % D;
                if (mode == 2'd1) begin
                    if (step) t = 1 + (p + 1) * D;
                    else if (c < D - 1) t = t + 1;
                end else if (mode != 2'd2) begin
                    t = t + 1;
                end
            end else begin
                g = t - 1 - N * D;
                if (mode == 2'd1) begin
                    if (step) t = PERIOD;
                    else if (g < G - 1) t = t + 1;
                end else if (mode != 2'd2) begin
                    t = t + 1;
                end
            end
            if (t >= PERIOD) t = 0;
        end
        #1;
    endtask

    function automatic logic [15:0] expv();
        int p, c;
        logic [3:0] dm, dl;
        logic [7:0] duty;
        logic [7:0] all_on;
        logic       lp, fs;
        logic [1:0] ix;
        if (rst || t == 0 || t > N * D) return 16'h0000;
        p = (t - 1) / D;
        c = (t - 1) % D;
        dm = snap[(N - 1 - p) * 4 +: 4];
        dl = snap[p * 4 +: 4];
        all_on = 8'hFF;
        duty = all_on >> p;
        if (c < F) lp = 1'b1;
        else if (p == N - 1) lp = 1'b0;
        else lp = (ph < int'(duty));
        ix = p[1:0];
        fs = (t == 1 && prev_t == 0);
        return {dm, lp, ix, fs, dl, lp, ix, fs};
    endfunction

    task automatic do_reset();
        rst = 1'b1; mode = 2'd0; step = 1'b0; value = 16'hA5C3;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd0; step = 1'b0; value = 16'hA5C3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 16'h0000) begin
                failures++;
                $display("FAIL reset_blank cyc=%0d got=%h exp=%h", i, obs, 16'h0000);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_auto();
        int fs_cyc[$];
        do_reset();
        for (int i = 1; i <= 80; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL auto cyc=%0d got=%h exp=%h", i, obs, expv());
            end
            if (fs_m) fs_cyc.push_back(i);
        end
        checks++;
        if (fs_cyc.size() < 2) begin
            failures++;
            $display("FAIL auto_period pulses=%0d exp>=2", fs_cyc.size());
        end else if (fs_cyc[0] != 1 || fs_cyc[1] - fs_cyc[0] != 37) begin
            failures++;
            $display("FAIL auto_period first=%0d period=%0d exp first=1 period=37", fs_cyc[0], fs_cyc[1] - fs_cyc[0]);
        end
    endtask

    task automatic test_value_change();
        do_reset();
        for (int i = 1; i <= 80; i++) begin
            if (i == 10) value = 16'h1234;
            tick();
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL value_change cyc=%0d got=%h exp=%h", i, obs, expv());
            end
            if (i == 12 || i == 38) begin
                checks++;
                if ({leds_m, leds_l} !== ((i == 12) ? 8'h5C : 8'h14)) begin
                    failures++;
                    $display("FAIL value_snapshot cyc=%0d got=%h exp=%h", i, {leds_m, leds_l}, (i == 12) ? 8'h5C : 8'h14);
                end
            end
        end
        value = 16'hA5C3;
    endtask

    task automatic test_step();
        do_reset();
        mode = 2'd1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            checks++;
            if (obs !== expv() || leds_m !== 4'hA) begin
                failures++;
                $display("FAIL step_hold cyc=%0d got=%h exp=%h", i, obs, expv());
            end
        end
        for (int s = 0; s < 6; s++) begin
            step = 1'b1;
            for (int i = 0; i < 6; i++) begin
                tick();
                step = 1'b0;
                checks++;
                if (obs !== expv()) begin
                    failures++;
                    $display("FAIL step_adv step=%0d cyc=%0d got=%h exp=%h", s, i, obs, expv());
                end
            end
        end
        mode = 2'd0;
    endtask

    task automatic test_freeze();
        do_reset();
        for (int i = 1; i <= 4; i++) tick();
        mode = 2'd2;
        for (int i = 0; i < 50; i++) begin
            step = (i % 7 == 3);
            tick();
            checks++;
            if (obs !== expv() || leds_m !== 4'hA || idx_m !== 2'd0) begin
                failures++;
                $display("FAIL freeze_hold cyc=%0d got=%h exp=%h", i, obs, expv());
            end
        end
        step = 1'b0;
        mode = 2'd0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL freeze_resume cyc=%0d got=%h exp=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_blank got=%h exp=%h", obs, 16'h0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            step = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) value = 16'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if (obs !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d mode=%0d got=%h exp=%h", i, mode, obs, expv());
            end
        end
        rst = 1'b0; step = 1'b0; mode = 2'd0;
    endtask

    initial begin
        test_reset();
        test_auto();
        test_value_change();
        test_step();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
